// File: rtl/ahb_lite_ram_resp.sv
// AHB-Lite RAM responder for the nanorv32 data port: byte/half/word access,
// programmable wait states, two-cycle ERROR and write-to-read forwarding.
// Optional write protection of offsets [0, RO_BYTES) under AHB_RAM_WPROT_EN.
module ahb_lite_ram_resp #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 0,
  parameter int RO_BYTES    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              wait_cnt, wait_cnt_nxt;
  logic                    ready, resp;
  logic                    accept, size_err, prot_err, err_acc;
  logic [ADDR_WIDTH-3:0]   a_idx;
  logic [3:0]              lane_mask;

  // Data-phase bookkeeping for the write currently waiting for hwdata
  logic                    d_write;
  logic [ADDR_WIDTH-3:0]   d_idx;
  logic [3:0]              d_mask;
  logic                    wr_done, fwd;
  logic [31:0]             rd_merged;

  logic [31:0]             mem [DEPTH];

  assign a_idx    = haddr[ADDR_WIDTH-1:2];
  assign accept   = hsel & htrans[1] & hready & ready;
  assign size_err = (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0])
                  | ((hsize == 3'd2) & (haddr[1:0] != 2'd0));

`ifdef AHB_RAM_WPROT_EN
  localparam logic [ADDR_WIDTH-1:0] RO_LIMIT = ADDR_WIDTH'(RO_BYTES);
  assign prot_err = hwrite & (haddr[ADDR_WIDTH-1:0] < RO_LIMIT);
`else
  localparam int unused_ro_bytes = RO_BYTES;
  assign prot_err = 1'b0;
`endif

  assign err_acc = size_err | prot_err;

  logic unused_bits;
  assign unused_bits = ^{haddr[31:ADDR_WIDTH], htrans[0]};

  always_comb begin
    lane_mask = 4'b1111;
    case (hsize)
      3'd0:    lane_mask = 4'b0001 << haddr[1:0];
      3'd1:    lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_comb begin
    ready = 1'b1;
    resp  = 1'b0;
    case (state)
      WAIT:    ready = (wait_cnt == 4'd0);
      ERR1:    begin ready = 1'b0; resp = 1'b1; end
      ERR2:    resp = 1'b1;
      default: ;
    endcase
  end

  assign hreadyout = ready;
  assign hresp     = resp;

  // Any cycle with ready high ends the current data phase, so the next
  // transfer is decided from the address phase presented alongside it.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      WAIT:    if (wait_cnt != 4'd0) wait_cnt_nxt = wait_cnt - 4'd1;
      ERR1:    state_nxt = ERR2;
      default: ;
    endcase
    if (ready) begin
      state_nxt = IDLE;
      if (accept) begin
        if (err_acc) begin
          state_nxt = ERR1;
        end else if (WAIT_STATES != 0) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 4'(WAIT_STATES);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  assign wr_done = d_write & ready;
  assign fwd     = wr_done & (d_idx == a_idx);

  // A read accepted on the edge that retires a write to the same word sees the new lanes
  always_comb begin
    rd_merged = mem[a_idx];
    for (int b = 0; b < 4; b++) begin
      if (fwd && d_mask[b]) rd_merged[8*b +: 8] = hwdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_write <= 1'b0;
      d_idx   <= '0;
      d_mask  <= 4'd0;
      hrdata  <= 32'd0;
    end else begin
      if (ready) begin
        d_write <= accept & hwrite & ~err_acc;
        d_idx   <= a_idx;
        d_mask  <= lane_mask;
      end
      if (accept && !hwrite && !err_acc) hrdata <= rd_merged;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_done && d_mask[b]) mem[d_idx][8*b +: 8] <= hwdata[8*b +: 8];
    end
  end

endmodule

// File: doc/ahb_lite_ram_resp.md
Name: ahb_lite_ram_resp

Overview:
AHB-Lite responder (slave) for the nanorv32 data port. It is the subordinate end of the haddrd/htransd/hwrited/hwdatad/hreadyd bus driven by the core.
- Single-port word RAM with byte/halfword/word access.
- Programmable wait states.
- Two-cycle ERROR response for illegal accesses.
- Write-to-read forwarding so back-to-back pipelined transfers are coherent.
Sits between the chip bus matrix and data RAM, in place of the zero-wait behavioural RAM.

Parameters:
ADDR_WIDTH, 16, byte-address bits decoded; depth = 2^(ADDR_WIDTH-2) words; upper haddr bits ignored (aliasing).
WAIT_STATES, 0, data-phase wait cycles per NONSEQ/SEQ transfer (0..15).
RO_BYTES, 0, size of the write-protected region starting at offset 0 (used only with AHB_RAM_WPROT_EN).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  32  byte address
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  1 = write
hsize  in  3  0 = byte, 1 = half, 2 = word
hwdata  in  32  write data (data phase)
hready  in  1  bus-level HREADY
hrdata  out  32  read data
hreadyout  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (async, rst_n=0):
  - hreadyout=1, hresp=0, hrdata=0.
  - FSM to IDLE, wait counter 0, pending-write register cleared.
  - RAM contents not reset.
- Address phase accepted at a rising edge when hsel & htrans[1] & hready. Latch addr, hwrite, hsize and byte-lane mask.
- Unselected, IDLE or BUSY: zero-wait OKAY, no RAM access.
- Byte lanes (little-endian):
  - hsize 0: lane haddr[1:0].
  - hsize 1: lanes {haddr[1],0},{haddr[1],1}.
  - hsize 2: all lanes.
- Illegal access:
  - hsize>2, hsize 1 with haddr[0]=1, or hsize 2 with haddr[1:0]≠0.
  - Response: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1). No RAM write.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE→WAIT on a legal accepted transfer when WAIT_STATES>0, counter loaded with WAIT_STATES.
  - WAIT holds hreadyout=0 while the counter is ≠0 and decrements it; at 0 it drives hreadyout=1 and returns to IDLE (or re-enters WAIT on a new accepted transfer).
  - IDLE→ERR1 on an illegal accepted transfer; ERR1→ERR2; ERR2→IDLE (a transfer presented during ERR2 is accepted normally).
- Data-phase cycles: exactly WAIT_STATES+1 for a legal transfer, 2 for an ERROR.
- Read: RAM read at the accepting edge. hrdata is valid in every cycle where hreadyout=1 ends the read data phase, holding the full word (all lanes). hrdata holds its last value otherwise.
- Write: hwdata sampled at the edge ending the data phase (hreadyout=1); only masked lanes are written.
- Forwarding: if a read address phase is accepted on the same edge that completes a write to the same word, hrdata returns the RAM word merged with the written lanes.
- Address alias: word index = haddr[ADDR_WIDTH-1:2].
- hready low from another slave: no acceptance, state unchanged.

Optional Feature:
AHB_RAM_WPROT_EN:
- Defined: any write with byte offset haddr[ADDR_WIDTH-1:0] < RO_BYTES takes the two-cycle ERROR response and memory is unchanged; reads are unaffected.
- Undefined: RO_BYTES ignored; all legal writes succeed.

Test Plan:
- WAIT_STATES=0: write word 0xCAFFE000 @0x10, then read @0x10 → hreadyout stays 1, hrdata=0xCAFFE000 in the read data phase, hresp=0.
- Back-to-back: byte write 0xAA @0x21, immediately followed by word read @0x20 (prior word 0x00000000) → hrdata=0x0000AA00 via forwarding.
- WAIT_STATES=3: word read → hreadyout low for exactly 3 cycles then high with data; bus held with hready=0 → no new acceptance.
- Halfword write @0x03 → hreadyout=0/hresp=1, then hreadyout=1/hresp=1; word @0x00 unchanged. Following NONSEQ accepted in ERR2 completes OKAY.
- Assert rst_n=0 mid WAIT → hreadyout=1, hresp=0, hrdata=0 immediately; pending write discarded.
- AHB_RAM_WPROT_EN, RO_BYTES=0x100:
  - write @0x80 → ERROR, memory unchanged.
  - write @0x100 → OKAY.
  - read @0x80 → OKAY, returns the original data.
